// File: rtl/jtframe_pocket_pkg.sv
// jtframe_pocket_pkg: unpacker FSM encoding, word geometry and byte-lane select
package jtframe_pocket_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_BYTE, ST_WAIT} state_t;
    localparam int BYTES_PER_WORD = 4;
    function automatic logic [7:0] byte_sel(input logic [31:0] data, input logic [1:0] idx, input logic swap);
        logic [1:0] k;
        k = swap ? 2'(BYTES_PER_WORD - 1) - idx : idx;
        return data[{k, 3'b000} +: 8];
    endfunction
endpackage

// File: rtl/jtframe_pocket_wfifo.sv
// jtframe_pocket_wfifo: word FIFO holding {address, data}; pushes while full are dropped
module jtframe_pocket_wfifo #(
    parameter int DW      = 55,
    parameter int FIFO_AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] o_dout,
    output logic          o_full,
    output logic          o_empty
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    logic [DW-1:0]      r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wp;
    logic [FIFO_AW-1:0] r_rp;
    logic [FIFO_AW:0]   r_cnt;
    logic               w_push;
    logic               w_pop;

    assign o_full  = r_cnt == FULL_CNT;
    assign o_empty = r_cnt == '0;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rp];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + FIFO_AW'(1);
            if (w_pop) r_rp <= r_rp + FIFO_AW'(1);
            r_cnt <= r_cnt + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_pop};
        end
    end
endmodule

// File: rtl/jtframe_pocket_unpack.sv
// jtframe_pocket_unpack: queues 32-bit bridge words and replays them as ioctl byte writes,
// one byte per prog_rdy handshake, while tracking the download window.
module jtframe_pocket_unpack
    import jtframe_pocket_pkg::*;
#(
    parameter int AW      = 25,
    parameter int FIFO_AW = 2,
    parameter bit SWAP    = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          word_wr,
    input  logic [31:0]   word_data,
    input  logic [31:0]   word_addr,
    input  logic          slot_done,
    input  logic          prog_rdy,
    output logic [AW-1:0] ioctl_addr,
    output logic [7:0]    ioctl_dout,
    output logic          ioctl_wr,
    output logic          downloading,
    output logic          fifo_full,
    output logic          ovf
);
    localparam int DW = AW - 2 + 32;
    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    state_t        r_st;
    logic [31:0]   r_data;
    logic [AW-3:0] r_waddr;
    logic [1:0]    r_idx;
    logic          r_pend;
    logic [DW-1:0] w_fdout;
    logic [1:0]    w_nidx;
    logic          w_empty;
    logic          w_pop;
    logic          w_unused;

    assign w_pop    = r_st == ST_LOAD;
    assign w_nidx   = r_idx + 2'd1;
    assign w_unused = ^{word_addr[31:AW], word_addr[1:0]};

    jtframe_pocket_wfifo #(.DW(DW), .FIFO_AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (word_wr),
        .i_pop   (w_pop),
        .i_din   ({word_addr[AW-1:2], word_data}),
        .o_dout  (w_fdout),
        .o_full  (fifo_full),
        .o_empty (w_empty)
    );

    // IDLE also wakes on the incoming push so the first byte leaves two cycles after word_wr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st       <= ST_IDLE;
            r_data     <= '0;
            r_waddr    <= '0;
            r_idx      <= '0;
            ioctl_wr   <= 1'b0;
            ioctl_addr <= '0;
            ioctl_dout <= '0;
        end else begin
            case (r_st)
                ST_IDLE: if (!w_empty || (word_wr && !fifo_full)) r_st <= ST_LOAD;
                ST_LOAD: begin
                    r_data     <= w_fdout[31:0];
                    r_waddr    <= w_fdout[DW-1:32];
                    r_idx      <= 2'd0;
                    ioctl_addr <= {w_fdout[DW-1:32], 2'd0};
                    ioctl_dout <= byte_sel(w_fdout[31:0], 2'd0, SWAP);
                    ioctl_wr   <= 1'b1;
                    r_st       <= ST_BYTE;
                end
                ST_BYTE: begin
                    ioctl_wr <= 1'b0;
                    r_st     <= ST_WAIT;
                end
                default: if (prog_rdy) begin
                    if (r_idx != LAST_IDX) begin
                        r_idx      <= w_nidx;
                        ioctl_addr <= {r_waddr, w_nidx};
                        ioctl_dout <= byte_sel(r_data, w_nidx, SWAP);
                        ioctl_wr   <= 1'b1;
                        r_st       <= ST_BYTE;
                    end else begin
                        r_st <= w_empty ? ST_IDLE : ST_LOAD;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            downloading <= 1'b0;
            r_pend      <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            if (word_wr && fifo_full) ovf <= 1'b1;
            if (word_wr) begin
                downloading <= 1'b1;
            end else if (r_pend && w_empty && r_st == ST_IDLE) begin
                downloading <= 1'b0;
                r_pend      <= 1'b0;
            end
            if (slot_done) r_pend <= 1'b1;
        end
    end
endmodule
